// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives MSB-first trial values into an
// external magnitude comparator and converges on the target from its gt/eq/lt verdicts.
module sar_search_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] trial,
  output logic             trial_valid,
  input  logic             cmp_valid,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err
);

  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB     = ONE << (WIDTH - 1);
  localparam logic [BW-1:0]    TOP_BIT = BW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, TRY, FIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             found_q, found_d;
  logic             err_q, err_d;
  logic             trial_valid_q, trial_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             verdict_ok;
  logic [WIDTH-1:0] next_mask;

  // Exactly one of gt/eq/lt must be asserted for a verdict to be usable.
  assign verdict_ok = (cmp_gt ^ cmp_eq ^ cmp_lt) & ~(cmp_gt & cmp_eq & cmp_lt);
  assign next_mask  = ONE << (bit_q - 1'b1);

  always_comb begin
    state_d  = state_q;
    trial_d  = trial_q;
    acc_d    = acc_q;
    result_d = result_q;
    bit_d    = bit_q;
    found_d  = found_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = TRY;
          acc_d    = '0;
          bit_d    = TOP_BIT;
          trial_d  = MSB;
          found_d  = 1'b0;
          err_d    = 1'b0;
          result_d = '0;
        end
      end

      TRY: begin
        if (cmp_valid) begin
          if (!verdict_ok) begin
            err_d    = 1'b1;
            found_d  = 1'b0;
            result_d = acc_q;
            state_d  = FIN;
          end else if (cmp_eq) begin
            acc_d    = trial_q;
            found_d  = 1'b1;
            result_d = trial_q;
            state_d  = FIN;
          end else begin
            acc_d = cmp_gt ? trial_q : acc_q;
            if (bit_q == '0) begin
              result_d = acc_d;
              state_d  = FIN;
            end else begin
              bit_d   = bit_q - 1'b1;
              trial_d = acc_d | next_mask;
            end
          end
        end
      end

      FIN: begin
        // result is loaded on the way into FIN so it is already valid alongside done.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    trial_valid_d = (state_d == TRY);
    busy_d        = (state_d == TRY);
    done_d        = (state_d == FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      trial_q       <= '0;
      acc_q         <= '0;
      result_q      <= '0;
      bit_q         <= '0;
      found_q       <= 1'b0;
      err_q         <= 1'b0;
      trial_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      trial_q       <= trial_d;
      acc_q         <= acc_d;
      result_q      <= result_d;
      bit_q         <= bit_d;
      found_q       <= found_d;
      err_q         <= err_d;
      trial_valid_q <= trial_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign trial       = trial_q;
  assign trial_valid = trial_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign found       = found_q;
  assign err         = err_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl: a table of searches answered by a target comparator model,
// with expected trial sequences queued per search, plus hand-written reset/idle sequences.
module tb_sar_search_ctrl;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] trial, result;
  logic       trial_valid, cmp_valid, cmp_gt, cmp_eq, cmp_lt;
  logic       busy, done, found, err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_trials[$];

  typedef struct {
    logic [7:0] tgt;
    int         dly;
    int         bad;
    bit         poke;
    logic [7:0] res;
    bit         fnd;
    bit         er;
    int         k;
  } vec_t;

  vec_t vecs[7];

  sar_search_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .trial(trial), .trial_valid(trial_valid),
    .cmp_valid(cmp_valid), .cmp_gt(cmp_gt), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
    .busy(busy), .done(done), .result(result), .found(found), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference SAR walk over an ideal comparator, producing the expected trial sequence.
  task automatic build_trials(input logic [7:0] tgt);
    logic [7:0] acc, t;
    exp_trials.delete();
    acc = 8'h00;
    for (int b = 7; b >= 0; b--) begin
      t = acc | (8'd1 << b);
      exp_trials.push_back(t);
      if (t == tgt) break;
      if (tgt > t) acc = t;
    end
  endtask

  task automatic run_search(input vec_t v, input int idx);
    int  lat, nver, wait_cnt;
    bit  seen_done;
    lat = 0; nver = 0; wait_cnt = 0; seen_done = 1'b0;
    build_trials(v.tgt);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    while (lat < 300 && !seen_done) begin
      @(negedge clk);
      lat++;
      start     = 1'b0;
      cmp_valid = 1'b0;
      cmp_gt    = 1'b0;
      cmp_eq    = 1'b0;
      cmp_lt    = 1'b0;
      if (lat == 1)
        check($sformatf("v%0d cleared_on_start", idx), {24'd0, result, 6'd0, found, err}, 32'd0);
      if (done) begin
        seen_done = 1'b1;
        check($sformatf("v%0d result", idx), 32'(result), 32'(v.res));
        check($sformatf("v%0d found", idx), 32'(found), 32'(v.fnd));
        check($sformatf("v%0d err", idx), 32'(err), 32'(v.er));
        check($sformatf("v%0d verdicts", idx), 32'(nver), 32'(v.k));
        check($sformatf("v%0d latency", idx), 32'(lat), 32'((v.dly + 1) * v.k + 1));
        check($sformatf("v%0d idle_with_done", idx), {30'd0, trial_valid, busy}, 32'd0);
      end else if (trial_valid) begin
        check($sformatf("v%0d busy", idx), 32'(busy), 32'd1);
        if (exp_trials.size() == 0) begin
          check($sformatf("v%0d extra_trial", idx), 32'(trial), 32'hFFFF_FFFF);
        end else begin
          check($sformatf("v%0d trial%0d", idx, nver), 32'(trial), 32'(exp_trials[0]));
          if (wait_cnt == v.dly) begin
            cmp_valid = 1'b1;
            if (nver == v.bad) begin
              cmp_gt = 1'b1;
              cmp_lt = 1'b1;
            end else begin
              cmp_gt = (v.tgt > trial);
              cmp_eq = (v.tgt == trial);
              cmp_lt = (v.tgt < trial);
            end
            if (v.poke && nver == 2) start = 1'b1;
            void'(exp_trials.pop_front());
            nver++;
            wait_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end
      end
    end
    if (!seen_done) check($sformatf("v%0d done_timeout", idx), 32'(lat), 32'd0);
    @(negedge clk);
    cmp_valid = 1'b0;
    check($sformatf("v%0d done_one_cycle", idx), 32'(done), 32'd0);
    check($sformatf("v%0d result_held", idx), 32'(result), 32'(v.res));
    $display("[TB] search %0d target=%02h dly=%0d -> result=%02h found=%0b err=%0b verdicts=%0d",
             idx, v.tgt, v.dly, result, found, err, nver);
  endtask

  task automatic run_reset_abort();
    int  lat, nver;
    bit  aborted, saw_done, saw_busy;
    lat = 0; nver = 0; aborted = 1'b0; saw_done = 1'b0; saw_busy = 1'b0;
    build_trials(8'hA5);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    while (lat < 50 && !aborted) begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      cmp_valid = 1'b0; cmp_gt = 1'b0; cmp_eq = 1'b0; cmp_lt = 1'b0;
      if (trial_valid) begin
        check($sformatf("rst trial%0d", nver), 32'(trial), 32'(exp_trials.pop_front()));
        if (nver == 3) begin
          rst = 1'b1;
          aborted = 1'b1;
        end else begin
          cmp_valid = 1'b1;
          cmp_gt = (8'hA5 > trial);
          cmp_eq = (8'hA5 == trial);
          cmp_lt = (8'hA5 < trial);
          nver++;
        end
      end
    end
    check("rst reached_4th_trial", 32'(aborted), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    check("rst outputs_zero", {12'd0, trial, result, trial_valid, busy, done, found}, 32'd0);
    check("rst err_zero", 32'(err), 32'd0);
    // Junk verdicts while idle must not start or finish anything.
    cmp_valid = 1'b1; cmp_gt = 1'b1;
    repeat (5) begin
      @(negedge clk);
      saw_done |= done;
      saw_busy |= busy;
    end
    cmp_valid = 1'b0; cmp_gt = 1'b0;
    check("rst no_done_after_abort", 32'(saw_done), 32'd0);
    check("idle ignores_cmp", 32'(saw_busy), 32'd0);
    $display("[TB] reset abort during 4th trial: outputs cleared, done=%0b", saw_done);
  endtask

  initial begin
    vecs[0] = '{tgt: 8'hA5, dly: 0, bad: -1, poke: 1'b0, res: 8'hA5, fnd: 1'b1, er: 1'b0, k: 8};
    vecs[1] = '{tgt: 8'h80, dly: 0, bad: -1, poke: 1'b0, res: 8'h80, fnd: 1'b1, er: 1'b0, k: 1};
    vecs[2] = '{tgt: 8'h00, dly: 0, bad: -1, poke: 1'b0, res: 8'h00, fnd: 1'b0, er: 1'b0, k: 8};
    vecs[3] = '{tgt: 8'hFF, dly: 0, bad: -1, poke: 1'b0, res: 8'hFF, fnd: 1'b1, er: 1'b0, k: 8};
    vecs[4] = '{tgt: 8'h3C, dly: 3, bad: -1, poke: 1'b0, res: 8'h3C, fnd: 1'b1, er: 1'b0, k: 6};
    vecs[5] = '{tgt: 8'h3C, dly: 0, bad:  1, poke: 1'b0, res: 8'h00, fnd: 1'b0, er: 1'b1, k: 2};
    vecs[6] = '{tgt: 8'h5B, dly: 0, bad: -1, poke: 1'b1, res: 8'h5B, fnd: 1'b1, er: 1'b0, k: 8};

    rst = 1'b1; start = 1'b0;
    cmp_valid = 1'b0; cmp_gt = 1'b0; cmp_eq = 1'b0; cmp_lt = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset outputs", {12'd0, trial, result, trial_valid, busy, done, found}, 32'd0);
    check("reset err", 32'(err), 32'd0);
    rst = 1'b0;
    $display("[TB] reset: all outputs zero");

    for (int i = 0; i < 7; i++) run_search(vecs[i], i);

    run_reset_abort();
    run_search(vecs[1], 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
